des_fp_output_stage: RTL and testbench
======================================

# des_fp_output_stage

Output stage of the DES datapath. Accepts the final round halves L16/R16 from the round engine, forms the preoutput block R16‖L16, and applies the DES final permutation FP (IP⁻¹, the exact inverse of the initial permutation). The result goes through a 2-entry valid/ready buffer, so the round engine is decoupled from downstream backpressure. A running count of emitted blocks is kept for debug and throughput measurement.

## Interface

- DEPTH, 2: buffer entries. The only supported value is 2.
- CNT_W, 32: width of the emitted-block counter.

- clk_i  input  1  single clock, rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  the round engine presents L16/R16.
- in_ready_o  output  1  the stage can accept a block.
- l16_i  input  [1:32]  left half after round 16 (DES numbering; bit 1 is the MSB).
- r16_i  input  [1:32]  right half after round 16.
- out_valid_o  output  1  the head entry is valid.
- out_ready_i  input  1  downstream accepts the head entry.
- data_o  output  [1:64]  ciphertext/plaintext block after FP.
- block_cnt_o  output  [CNT_W-1:0]  number of blocks popped; wraps modulo 2^CNT_W.

## Operation

- Preoutput: pre[1:32] = r16_i and pre[33:64] = l16_i (halves swapped).
- FP (combinational, applied on the input side before storage):
  - Output index j = 8r+c+1, with r,c = 0..7.
  - If c is even: data[j] = pre[40 − r + 4c].
  - If c is odd: data[j] = pre[8 − r + 4(c−1)].
  - First row: 40 8 48 16 56 24 64 32. Last row: 33 1 41 9 49 17 57 25.
  - FP composed with IP must be the identity on all 64 bits.
- Buffer: a 2-entry FIFO built from a registered head and tail plus an occupancy count (0, 1 or 2).
  - Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
  - State EMPTY (count 0): a push goes to the head, next state ONE.
  - State ONE (count 1):
    - push only → FULL;
    - pop only → EMPTY;
    - push and pop together → stays ONE, and the new block replaces the head.
  - State FULL (count 2):
    - pop → ONE, and the tail moves to the head;
    - no push is possible, because in_ready_o is low.
  - Order is strict FIFO. No block is ever dropped or duplicated.
- in_ready_o = (count != 2). It is registered/state-derived only, with no combinational path from out_ready_i.
- out_valid_o = (count != 0). data_o is always driven from the head register.
- block_cnt_o increments by 1 on each pop. It wraps from all-ones to 0.
- Data registers need no reset. Control registers and the counter do.

## Timing

- Reset values (asynchronous, while rst_n_i = 0):
  - count = 0, so out_valid_o = 0 and in_ready_o = 1;
  - block_cnt_o = 0;
  - data_o = 64'h0.
- Reset asserted mid-operation discards every stored block immediately. There is no partial output after deassertion.
- Latency: a block pushed at edge N appears on data_o with out_valid_o = 1 after edge N, provided the buffer was empty.
- Throughput: one block per cycle when out_ready_i stays high. In steady state count stays at 1.
- Backpressure:
  - If out_ready_i is low, out_valid_o and data_o hold stable until popped.
  - After 2 unpopped pushes, in_ready_o drops on the following cycle.
- From FULL, one pop raises in_ready_o one cycle later. It is never raised in the same cycle as the pop.
- in_valid_i/l16_i/r16_i may change freely while in_ready_o = 0. They are ignored.

## Test plan

- Known-answer test:
  - Stimulus: l16_i = 32'h43423234, r16_i = 32'h0A4CD995 (key 133457799BBCDFF1, plaintext 0123456789ABCDEF).
  - Required: data_o = 64'h85E813540F0AB405 one cycle later, and block_cnt_o = 1 after the pop.
- Single-bit walk:
  - Stimulus: l16_i = 32'h01000000, r16_i = 0 (pre bit 40 set).
  - Required: data_o = 64'h8000000000000000.
  - Repeat for all 64 pre bits and check against the FP table.
  - Cross-check: driving IP(x) and then FP gives x for 1000 random x.
- Backpressure:
  - Stimulus: hold out_ready_i = 0 and push blocks A, B, C.
  - Required: A and B accepted; in_ready_o = 0 while C is offered; data_o = A, stable.
  - Then release out_ready_i. Required order: A, B, then C. in_ready_o rises one cycle after the first pop.
- Streaming:
  - Stimulus: 100 back-to-back pushes with out_ready_i = 1.
  - Required: 100 outputs on consecutive cycles, in order, with block_cnt_o = 100.
  - Then randomize out_ready_i and in_valid_i. Required: no loss and no duplication against a scoreboard.
- Reset mid-stream:
  - Stimulus: assert rst_n_i = 0 asynchronously while count = 2.
  - Required: out_valid_o = 0, in_ready_o = 1 and block_cnt_o = 0 immediately.
  - After release, the first output is the first block pushed after reset.
- Counter wrap:
  - Stimulus: CNT_W = 4, then 17 pops.
  - Required: block_cnt_o goes 15 → 0 → 1.

Source files
------------

// File: rtl/des_fp_output_stage_if.sv
// Handshake bundle between the DES round engine, the FP output stage and the downstream consumer.
// The stage itself connects through the slave modport.
interface des_fp_output_stage_if #(
  parameter int CNT_W = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:32]      l16_i;
  logic [1:32]      r16_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [1:64]      data_o;
  logic [CNT_W-1:0] block_cnt_o;

  modport master (
    output in_valid_i, l16_i, r16_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, block_cnt_o
  );

  modport slave (
    input  in_valid_i, l16_i, r16_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, block_cnt_o
  );
endinterface

// File: rtl/des_fp_output_stage.sv
// DES output stage: swaps L16/R16, applies the final permutation (IP^-1) and buffers
// the result in a 2-entry head/tail FIFO with an emitted-block counter.
module des_fp_output_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  des_fp_output_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'(DEPTH)
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:64]      r_head;
  logic [1:64]      r_tail;
  logic [CNT_W-1:0] r_block_cnt;

  logic [1:64]      w_pre;
  logic [1:64]      w_fp;
  logic             w_push;
  logic             w_pop;

  assign w_pre  = {bus.r16_i, bus.l16_i};
  assign w_push = bus.in_valid_i & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready_i;

  // FP table in closed form: even columns read from the upper half of pre, odd from the lower.
  genvar gr, gc;
  generate
    for (gr = 0; gr < 8; gr++) begin : g_row
      for (gc = 0; gc < 8; gc++) begin : g_col
        if ((gc % 2) == 0) begin : g_even
          assign w_fp[8*gr+gc+1] = w_pre[40-gr+4*gc];
        end else begin : g_odd
          assign w_fp[8*gr+gc+1] = w_pre[8-gr+4*(gc-1)];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_block_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_block_cnt <= r_block_cnt + CNT_W'(1);
      end
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head      <= w_fp;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_fp;
          end else if (w_push) begin
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen
          if (w_pop) begin
            r_head     <= r_tail;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if ((r_state == S_ONE) && w_push && !w_pop) begin
      r_tail <= w_fp;
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.data_o      = r_head;
  assign bus.block_cnt_o = r_block_cnt;

endmodule

// File: tb/tb_des_fp_output_stage.sv
// Scoreboard bench for des_fp_output_stage: a driver queues expected FP results on each accepted
// push, a forked monitor pops and compares on every output handshake.
module tb_des_fp_output_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_fp_output_stage_if #(.CNT_W(32)) bus ();
  des_fp_output_stage_if #(.CNT_W(4))  bus4 ();

  des_fp_output_stage #(.DEPTH(2), .CNT_W(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  des_fp_output_stage #(.DEPTH(2), .CNT_W(4)) dut4 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus4)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  int n_pop = 0;
  int n_push = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int pops4 = 0;
  int c0 = 0;

  // Standard DES tables, 1-based bit numbers with bit 1 as MSB
  int fp_tab[64] = '{40, 8, 48, 16, 56, 24, 64, 32,
                     39, 7, 47, 15, 55, 23, 63, 31,
                     38, 6, 46, 14, 54, 22, 62, 30,
                     37, 5, 45, 13, 53, 21, 61, 29,
                     36, 4, 44, 12, 52, 20, 60, 28,
                     35, 3, 43, 11, 51, 19, 59, 27,
                     34, 2, 42, 10, 50, 18, 58, 26,
                     33, 1, 41,  9, 49, 17, 57, 25};
  int ip_tab[64] = '{58, 50, 42, 34, 26, 18, 10, 2,
                     60, 52, 44, 36, 28, 20, 12, 4,
                     62, 54, 46, 38, 30, 22, 14, 6,
                     64, 56, 48, 40, 32, 24, 16, 8,
                     57, 49, 41, 33, 25, 17,  9, 1,
                     59, 51, 43, 35, 27, 19, 11, 3,
                     61, 53, 45, 37, 29, 21, 13, 5,
                     63, 55, 47, 39, 31, 23, 15, 7};

  function automatic logic [63:0] fp_model(input logic [63:0] pre);
    logic [63:0] o;
    o = '0;
    for (int j = 1; j <= 64; j++) o[64-j] = pre[64-fp_tab[j-1]];
    return o;
  endfunction

  function automatic logic [63:0] ip_model(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int j = 1; j <= 64; j++) o[64-j] = x[64-ip_tab[j-1]];
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [63:0] e);
    bit done;
    done = 1'b0;
    bus.l16_i = l;
    bus.r16_i = r;
    bus.in_valid_i = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        exp_q.push_back(e);
        n_push++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic drain();
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_pop = 0;
    n_push = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] pre, x, y;
    logic [31:0] rl, rr;

    bus.in_valid_i = 1'b0;
    bus.l16_i = '0;
    bus.r16_i = '0;
    bus.out_ready_i = 1'b0;
    bus4.in_valid_i = 1'b0;
    bus4.l16_i = '0;
    bus4.r16_i = '0;
    bus4.out_ready_i = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got %h expected no output", bus.data_o);
          end else begin
            chk("sb_data", bus.data_o, exp_q.pop_front());
          end
          if (n_pop == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          n_pop++;
        end
      end
    join_none

    #12;
    chk("reset_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("reset_block_cnt", bus.block_cnt_o, 64'd0);
    chk("reset_data", bus.data_o, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known answer
    bus.out_ready_i = 1'b1;
    send(32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("kat_latency_valid", 64'(bus.out_valid_o), 64'd1);
    @(posedge clk);
    #1;
    chk("kat_block_cnt", bus.block_cnt_o, 64'd1);
    do_reset();

    // 100 back-to-back blocks
    bus.out_ready_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      rl = $urandom;
      rr = $urandom;
      send(rl, rr, fp_model({rr, rl}));
    end
    chk("stream_push_cycles", 64'(cyc - c0), 64'd100);
    drain();
    chk("stream_block_cnt", bus.block_cnt_o, 64'd100);
    chk("stream_pop_count", 64'(n_pop), 64'd100);
    chk("stream_pop_span", 64'(last_pop_cyc - first_pop_cyc), 64'd99);

    // Single-bit walk and IP/FP round trip
    send(32'h01000000, 32'h0, 64'h8000000000000000);
    for (int k = 0; k < 64; k++) begin
      pre = 64'h1 << k;
      send(pre[31:0], pre[63:32], fp_model(pre));
    end
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = ip_model(x);
      send(y[31:0], y[63:32], x);
    end
    drain();

    // Backpressure: A, B accepted, C held off until the first pop
    bus.out_ready_i = 1'b0;
    send(32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405);
    send(32'h01000000, 32'h0, 64'h8000000000000000);
    bus.l16_i = 32'hDEADBEEF;
    bus.r16_i = 32'h12345678;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", 64'(bus.in_ready_o), 64'd0);
    chk("bp_head_A", bus.data_o, 64'h85E813540F0AB405);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_head_stable", bus.data_o, 64'h85E813540F0AB405);
    chk("bp_valid_held", 64'(bus.out_valid_o), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_not_same_cycle", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_rises", 64'(bus.in_ready_o), 64'd1);
    if (bus.in_ready_o) begin
      exp_q.push_back(fp_model({32'h12345678, 32'hDEADBEEF}));
      n_push++;
    end
    @(posedge clk);
    #1;
    drain();

    // Random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      rl = $urandom;
      rr = $urandom;
      bus.in_valid_i = 1'($urandom_range(0, 1));
      bus.l16_i = rl;
      bus.r16_i = rr;
      bus.out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back(fp_model({rr, rl}));
        n_push++;
      end
      @(posedge clk);
      #1;
    end
    drain();
    chk("rand_block_cnt", bus.block_cnt_o, 64'(n_push));

    // Asynchronous reset while full
    bus.out_ready_i = 1'b0;
    send(32'h11111111, 32'h22222222, fp_model({32'h22222222, 32'h11111111}));
    send(32'h33333333, 32'h44444444, fp_model({32'h44444444, 32'h33333333}));
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_full_in_ready", 64'(bus.in_ready_o), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("mid_rst_block_cnt", bus.block_cnt_o, 64'd0);
    exp_q.delete();
    n_pop = 0;
    n_push = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    send(32'h0A4CD995, 32'h43423234, fp_model({32'h43423234, 32'h0A4CD995}));
    drain();
    chk("mid_post_pops", 64'(n_pop), 64'd1);
    chk("mid_post_block_cnt", bus.block_cnt_o, 64'd1);

    // 4-bit counter wrap
    bus4.in_valid_i = 1'b1;
    bus4.out_ready_i = 1'b1;
    for (int t = 0; t < 60 && pops4 < 17; t++) begin
      @(negedge clk);
      if (bus4.out_valid_o && bus4.out_ready_i) begin
        @(posedge clk);
        #1;
        pops4++;
        if (pops4 == 15) chk("wrap_15", 64'(bus4.block_cnt_o), 64'd15);
        if (pops4 == 16) chk("wrap_16", 64'(bus4.block_cnt_o), 64'd0);
        if (pops4 == 17) chk("wrap_17", 64'(bus4.block_cnt_o), 64'd1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("wrap_pops", 64'(pops4), 64'd17);
    bus4.in_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
